// File: rtl/mem_responder_if.sv
// mem_responder_if -- bundles the request/response signals of mem_responder.
//   Requester side : iREN/iaddr, dREN/dWEN/daddr/dstore, halt  -> responder
//                    ihit/dhit, iload/dload, busy, err          <- responder
//   RAM side       : ramREN/ramWEN/ramaddr/ramstore             <- responder
//                    ramload/ramready                           -> responder
// Modport slave is the responder's view; master is the view of whatever
// drives the requests and models the RAM (cpu + memory side).
interface mem_responder_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        halt;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        busy;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramready,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, busy, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramready,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder -- arbitrates instruction and data requests onto a single RAM
// port, one access outstanding at a time, with a wait-cycle timeout.
// Ports:
//   CLK  : clock, rising edge
//   nRst : asynchronous active-low reset
//   bus  : mem_responder_if.slave (requests, hits, load data, RAM port,
//          busy and sticky err flag)
// Parameters:
//   MAXWAIT : RAM wait cycles before an access is aborted (2..255)
//   ERRWORD : load value returned by an aborted read
module mem_responder #(
  parameter int          MAXWAIT = 16,
  parameter logic [31:0] ERRWORD = 32'hBAD0BAD0
) (
  input logic            CLK,
  input logic            nRst,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

  // Timeout fires when the counter already shows MAXWAIT-1 elapsed waits,
  // i.e. on the MAXWAIT-th cycle spent in the access state.
  localparam logic [7:0] WAIT_LIMIT = 8'(MAXWAIT - 1);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] store_reg, store_next;
  logic        is_write_reg, is_write_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [31:0] iload_reg, iload_next;
  logic [31:0] dload_reg, dload_next;
  logic        ihit_reg, ihit_next;
  logic        dhit_reg, dhit_next;
  logic        err_reg, err_next;

  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;

  always_ff @(posedge CLK or negedge nRst) begin
    if (!nRst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      store_reg    <= '0;
      is_write_reg <= 1'b0;
      wait_cnt_reg <= '0;
      iload_reg    <= '0;
      dload_reg    <= '0;
      ihit_reg     <= 1'b0;
      dhit_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      store_reg    <= store_next;
      is_write_reg <= is_write_next;
      wait_cnt_reg <= wait_cnt_next;
      iload_reg    <= iload_next;
      dload_reg    <= dload_next;
      ihit_reg     <= ihit_next;
      dhit_reg     <= dhit_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    store_next    = store_reg;
    is_write_next = is_write_reg;
    wait_cnt_next = wait_cnt_reg;
    iload_next    = iload_reg;
    dload_next    = dload_reg;
    ihit_next     = 1'b0;
    dhit_next     = 1'b0;
    err_next      = err_reg;
    ram_ren       = 1'b0;
    ram_wen       = 1'b0;
    ram_addr      = '0;
    ram_store     = '0;

    case (state_reg)
      IDLE: begin
        if (!bus.halt) begin
          // Data side wins; a simultaneous dREN/dWEN pair is treated as a write.
          if (bus.dREN || bus.dWEN) begin
            state_next    = DACC;
            addr_next     = bus.daddr;
            store_next    = bus.dstore;
            is_write_next = bus.dWEN;
            wait_cnt_next = '0;
          end else if (bus.iREN) begin
            state_next    = IACC;
            addr_next     = bus.iaddr;
            store_next    = '0;
            is_write_next = 1'b0;
            wait_cnt_next = '0;
          end
        end
      end

      IACC: begin
        ram_ren  = 1'b1;
        ram_addr = addr_reg;
        if (bus.ramready) begin
          state_next = RESP;
          iload_next = bus.ramload;
          ihit_next  = 1'b1;
        end else if (wait_cnt_reg == WAIT_LIMIT) begin
          state_next = RESP;
          iload_next = ERRWORD;
          ihit_next  = 1'b1;
          err_next   = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end

      DACC: begin
        ram_ren   = !is_write_reg;
        ram_wen   = is_write_reg;
        ram_addr  = addr_reg;
        ram_store = store_reg;
        if (bus.ramready) begin
          state_next = RESP;
          if (!is_write_reg) dload_next = bus.ramload;
          dhit_next  = 1'b1;
        end else if (wait_cnt_reg == WAIT_LIMIT) begin
          // Aborted write is simply dropped; aborted read returns ERRWORD.
          state_next = RESP;
          if (!is_write_reg) dload_next = ERRWORD;
          dhit_next  = 1'b1;
          err_next   = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end

      // One cycle with the hit high; requests are deliberately not sampled
      // here so a requester dropping its line after the hit is not re-served.
      RESP: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.ihit     = ihit_reg;
  assign bus.dhit     = dhit_reg;
  assign bus.iload    = iload_reg;
  assign bus.dload    = dload_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- table-driven directed bench for mem_responder plus
// hand-written sequences for arbitration, halt and mid-access reset.
module tb_mem_responder;

  logic CLK;
  logic nRst;
  mem_responder_if bus ();

  mem_responder #(.MAXWAIT(16), .ERRWORD(32'hBAD0BAD0)) dut (
    .CLK  (CLK),
    .nRst (nRst),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ready_at: ACC cycle index (0-based) where ramready is raised; 255 = never.
  // acc_cycles: number of cycles the access state is expected to last.
  typedef struct {
    logic        ireq, dren, dwen;
    logic [31:0] iaddr, daddr, dstore, ramload;
    int          ready_at, acc_cycles;
    logic        exp_ren, exp_wen;
    logic [31:0] exp_addr, exp_store;
    logic        exp_ihit, exp_dhit;
    logic [31:0] exp_iload, exp_dload;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic idle_inputs();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.halt = 0;
    bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0;
    bus.ramload = 0; bus.ramready = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bus.iREN = v.ireq; bus.dREN = v.dren; bus.dWEN = v.dwen;
    bus.iaddr = v.iaddr; bus.daddr = v.daddr; bus.dstore = v.dstore;
    bus.ramready = 0;
    for (int k = 0; k < v.acc_cycles; k++) begin
      @(negedge CLK);
      chk($sformatf("v%0d.c%0d.busy", idx, k), 32'(bus.busy), 32'd1);
      chk($sformatf("v%0d.c%0d.ramREN", idx, k), 32'(bus.ramREN), 32'(v.exp_ren));
      chk($sformatf("v%0d.c%0d.ramWEN", idx, k), 32'(bus.ramWEN), 32'(v.exp_wen));
      chk($sformatf("v%0d.c%0d.ramaddr", idx, k), bus.ramaddr, v.exp_addr);
      chk($sformatf("v%0d.c%0d.ramstore", idx, k), bus.ramstore, v.exp_store);
      chk($sformatf("v%0d.c%0d.hits", idx, k), 32'({bus.ihit, bus.dhit}), 32'd0);
      if (k == v.ready_at) begin
        bus.ramready = 1; bus.ramload = v.ramload;
      end else begin
        bus.ramready = 0; bus.ramload = 32'h0F0F0F0F;
      end
    end
    @(negedge CLK);  // RESP
    bus.ramready = 0;
    chk($sformatf("v%0d.ihit", idx), 32'(bus.ihit), 32'(v.exp_ihit));
    chk($sformatf("v%0d.dhit", idx), 32'(bus.dhit), 32'(v.exp_dhit));
    chk($sformatf("v%0d.iload", idx), bus.iload, v.exp_iload);
    chk($sformatf("v%0d.dload", idx), bus.dload, v.exp_dload);
    chk($sformatf("v%0d.err", idx), 32'(bus.err), 32'(v.exp_err));
    chk($sformatf("v%0d.resp_ram", idx), 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    @(negedge CLK);  // IDLE
    chk($sformatf("v%0d.idle_busy", idx), 32'(bus.busy), 32'd0);
    chk($sformatf("v%0d.idle_hits", idx), 32'({bus.ihit, bus.dhit}), 32'd0);
    $display("txn %0d: ihit=%0b dhit=%0b iload=%h dload=%h err=%0b",
             idx, v.exp_ihit, v.exp_dhit, bus.iload, bus.dload, bus.err);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ihit"}, 32'(bus.ihit), 32'd0);
    chk({tag, ".dhit"}, 32'(bus.dhit), 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".err"}, 32'(bus.err), 32'd0);
    chk({tag, ".iload"}, bus.iload, 32'd0);
    chk({tag, ".dload"}, bus.dload, 32'd0);
    chk({tag, ".ram_en"}, 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    chk({tag, ".ramaddr"}, bus.ramaddr, 32'd0);
    chk({tag, ".ramstore"}, bus.ramstore, 32'd0);
  endtask

  initial begin
    //          ireq dren dwen iaddr  daddr   dstore        ramload       rdy acc ren wen addr    store         ih dh iload         dload         err
    vecs[0] = '{1, 0, 0, 32'h40, 32'h0,   32'h0,        32'h8C010004, 0,   1,  1, 0, 32'h40,  32'h0,        1, 0, 32'h8C010004, 32'h0,        0};
    vecs[1] = '{0, 1, 0, 32'h0,  32'h200, 32'h0,        32'h12345678, 2,   3,  1, 0, 32'h200, 32'h0,        0, 1, 32'h8C010004, 32'h12345678, 0};
    vecs[2] = '{0, 0, 1, 32'h0,  32'h100, 32'hDEADBEEF, 32'h77777777, 1,   2,  0, 1, 32'h100, 32'hDEADBEEF, 0, 1, 32'h8C010004, 32'h12345678, 0};
    vecs[3] = '{0, 1, 1, 32'h0,  32'h104, 32'hCAFEF00D, 32'h66666666, 0,   1,  0, 1, 32'h104, 32'hCAFEF00D, 0, 1, 32'h8C010004, 32'h12345678, 0};
    vecs[4] = '{1, 0, 0, 32'h44, 32'h0,   32'h0,        32'h00000001, 15,  16, 1, 0, 32'h44,  32'h0,        1, 0, 32'h00000001, 32'h12345678, 0};
    vecs[5] = '{0, 1, 0, 32'h0,  32'h300, 32'h0,        32'h0,        255, 16, 1, 0, 32'h300, 32'h0,        0, 1, 32'h00000001, 32'hBAD0BAD0, 1};
    vecs[6] = '{1, 0, 0, 32'h48, 32'h0,   32'h0,        32'hA5A5A5A5, 0,   1,  1, 0, 32'h48,  32'h0,        1, 0, 32'hA5A5A5A5, 32'hBAD0BAD0, 1};
    vecs[7] = '{0, 0, 1, 32'h0,  32'h400, 32'h11111111, 32'h0,        255, 16, 0, 1, 32'h400, 32'h11111111, 0, 1, 32'hA5A5A5A5, 32'hBAD0BAD0, 1};
    vecs[8] = '{1, 0, 0, 32'h4C, 32'h0,   32'h0,        32'h0,        255, 16, 1, 0, 32'h4C,  32'h0,        1, 0, 32'hBAD0BAD0, 32'hBAD0BAD0, 1};

    idle_inputs();
    nRst = 0;
    bus.iREN = 1; bus.iaddr = 32'h40;  // requests during reset must be ignored
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    $display("txn reset: outputs checked while nRst low");
    idle_inputs();
    nRst = 1;
    @(negedge CLK);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Simultaneous iREN + dWEN: data write first, then the held iREN.
    bus.iREN = 1; bus.iaddr = 32'h80; bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
    @(negedge CLK);
    chk("arb.d_wen", 32'({bus.ramREN, bus.ramWEN}), 32'b01);
    chk("arb.d_store", bus.ramstore, 32'hDEADBEEF);
    chk("arb.d_addr", bus.ramaddr, 32'h100);
    bus.ramready = 1;
    @(negedge CLK);
    bus.ramready = 0;
    chk("arb.dhit", 32'({bus.ihit, bus.dhit}), 32'b01);
    bus.dWEN = 0;
    @(negedge CLK);
    chk("arb.idle", 32'(bus.busy), 32'd0);
    @(negedge CLK);
    chk("arb.i_ren", 32'({bus.ramREN, bus.ramWEN}), 32'b10);
    chk("arb.i_addr", bus.ramaddr, 32'h80);
    bus.ramready = 1; bus.ramload = 32'h24420001;
    @(negedge CLK);
    bus.ramready = 0;
    chk("arb.ihit", 32'({bus.ihit, bus.dhit}), 32'b10);
    chk("arb.iload", bus.iload, 32'h24420001);
    bus.iREN = 0;
    @(negedge CLK);
    $display("txn arb: write then instruction read");

    // halt blocks acceptance in IDLE.
    bus.halt = 1; bus.iREN = 1; bus.iaddr = 32'h90;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("halt.c%0d.busy", k), 32'(bus.busy), 32'd0);
      chk($sformatf("halt.c%0d.ramREN", k), 32'(bus.ramREN), 32'd0);
    end
    bus.iREN = 0; bus.halt = 0;
    // halt raised mid-DACC does not abort.
    bus.dREN = 1; bus.daddr = 32'h500;
    @(negedge CLK);
    chk("halt.dacc", 32'(bus.ramREN), 32'd1);
    bus.halt = 1;
    @(negedge CLK);
    chk("halt.still_busy", 32'(bus.busy), 32'd1);
    bus.ramready = 1; bus.ramload = 32'h5A5A0000;
    @(negedge CLK);
    bus.ramready = 0;
    chk("halt.dhit", 32'(bus.dhit), 32'd1);
    chk("halt.dload", bus.dload, 32'h5A5A0000);
    bus.dREN = 0; bus.halt = 0;
    @(negedge CLK);
    $display("txn halt: blocked in IDLE, mid-access completes");

    // Reset in IACC after 3 wait cycles; held iREN served afresh afterwards.
    bus.iREN = 1; bus.iaddr = 32'hA0;
    repeat (4) @(negedge CLK);
    chk("rst.pre_busy", 32'(bus.busy), 32'd1);
    #2 nRst = 0;
    #1 chk_all_zero("rst.async");
    @(negedge CLK);
    chk("rst.no_ihit", 32'(bus.ihit), 32'd0);
    nRst = 1;
    @(negedge CLK);
    chk("rst.reacc", 32'(bus.ramREN), 32'd1);
    chk("rst.readdr", bus.ramaddr, 32'hA0);
    bus.ramready = 1; bus.ramload = 32'hC0FFEE00;
    @(negedge CLK);
    bus.ramready = 0;
    chk("rst.ihit", 32'(bus.ihit), 32'd1);
    chk("rst.iload", bus.iload, 32'hC0FFEE00);
    chk("rst.err", 32'(bus.err), 32'd0);
    bus.iREN = 0;
    @(negedge CLK);
    $display("txn reset_mid_access: re-served after release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
